// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt pending controller.
//   NUM_IRQ : number of request lines (8)
//   ID_W    : width of a request index (3)
//   state_t : presentation FSM state encoding
package irq_ctrl_pkg;

  localparam int NUM_IRQ = 8;
  localparam int ID_W    = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder used to pick the next request to present.
// The highest set index wins.
//   vec : candidate request vector
//   idx : index of the highest set bit (0 when vec is zero)
//   any : at least one bit of vec is set
module irq_prio_enc #(
  parameter int NUM_IRQ = irq_ctrl_pkg::NUM_IRQ,
  parameter int ID_W    = irq_ctrl_pkg::ID_W
) (
  input  logic [NUM_IRQ-1:0] vec,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  // Ascending scan: later (higher) indices overwrite earlier ones.
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (vec[i]) idx = ID_W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt pending controller: captures rising edges on the request lines
// into a pending register, tracks overruns, applies a mask and presents the
// highest-index unmasked pending request over a valid/ready handshake.
//   clk, rst   : clock, synchronous active-high reset
//   en         : presentation enable (capture is unaffected)
//   irq_in     : raw level request lines
//   mask_we    : mask write strobe, mask_wdata is the new mask (1 = masked)
//   ovr_clr    : clears all overrun flags
//   irq_valid  : a request is presented, irq_id is its index
//   irq_ready  : consumer accepts the presented request
//   pending    : pending register
//   mask       : mask register
//   overrun    : sticky per-line overrun flags
module irq_pending_ctrl #(
  parameter int NUM_IRQ = irq_ctrl_pkg::NUM_IRQ,
  parameter int ID_W    = irq_ctrl_pkg::ID_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               ovr_clr,
  output logic               irq_valid,
  input  logic               irq_ready,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask,
  output logic [NUM_IRQ-1:0] overrun
);

  import irq_ctrl_pkg::*;

  state_t             state;
  state_t             state_nx;
  logic               valid_nx;
  logic [ID_W-1:0]    id_nx;

  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] edge_det;
  logic [NUM_IRQ-1:0] clr_vec;
  logic [NUM_IRQ-1:0] ovr_set;
  logic [NUM_IRQ-1:0] cand;
  logic [ID_W-1:0]    win_id;
  logic               win_any;
  logic               accept;

  assign edge_det = irq_in & ~irq_prev;
  assign accept   = irq_valid & irq_ready;
  assign clr_vec  = accept ? (NUM_IRQ'(1) << irq_id) : '0;
  // An edge on the line being accepted re-arms it rather than overrunning.
  assign ovr_set  = edge_det & pending & ~clr_vec;
  assign cand     = pending & ~mask;

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_prio (
    .vec (cand),
    .idx (win_id),
    .any (win_any)
  );

  // Capture, mask and overrun registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_prev <= '0;
      pending  <= '0;
      overrun  <= '0;
      mask     <= '1;
    end else begin
      irq_prev <= irq_in;
      pending  <= (pending & ~clr_vec) | edge_det;
      overrun  <= (ovr_clr ? '0 : overrun) | ovr_set;
      if (mask_we) mask <= mask_wdata;
    end
  end

  // Presentation FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      irq_valid <= 1'b0;
      irq_id    <= '0;
    end else begin
      state     <= state_nx;
      irq_valid <= valid_nx;
      irq_id    <= id_nx;
    end
  end

  // Once presented, the index is frozen until accepted; returning to IDLE
  // on accept gives the one-cycle bubble before the next presentation.
  always_comb begin
    state_nx = state;
    valid_nx = 1'b0;
    id_nx    = irq_id;
    case (state)
      IDLE: begin
        if (en && win_any) begin
          state_nx = PRESENT;
          valid_nx = 1'b1;
          id_nx    = win_id;
        end
      end
      PRESENT: begin
        valid_nx = 1'b1;
        if (irq_ready) begin
          state_nx = IDLE;
          valid_nx = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule
